axis_lane_serializer: RTL and testbench

AXIS_LANE_SERIALIZER -- requirements
Module: axis_lane_serializer

---
 rtl/axis_pkg.sv | 9 +
 rtl/axis_lane_serializer_if.sv | 42 ++++
 rtl/axis_lane_serializer.sv | 101 ++++++++++
 tb/tb_axis_lane_serializer.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream sample types for the lane serializer.
// Provides sample_t, the unit of data carried on every lane.
package axis_pkg;

   localparam int SAMPLE_W = 16;

   typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/axis_lane_serializer_if.sv
// Handshake bundle for the lane serializer: a parallel input stream
// (BUS_NUM lanes per beat) and a one-sample-per-beat serial output stream.
// slave  : the serializer side (consumes in_*, produces out_*).
// master : the environment side (produces in_*, consumes out_*).
interface axis_lane_serializer_if
   import axis_pkg::*;
#(
   parameter int BUS_NUM = 2
);

   logic                    in_tvalid;
   logic                    in_tready;
   logic                    in_tlast;
   sample_t [BUS_NUM-1:0]   in_tdata;
   logic                    out_tvalid;
   logic                    out_tready;
   logic                    out_tlast;
   sample_t                 out_tdata;

   modport slave (
      input  in_tvalid,
      input  in_tlast,
      input  in_tdata,
      input  out_tready,
      output in_tready,
      output out_tvalid,
      output out_tlast,
      output out_tdata
   );

   modport master (
      output in_tvalid,
      output in_tlast,
      output in_tdata,
      output out_tready,
      input  in_tready,
      input  out_tvalid,
      input  out_tlast,
      input  out_tdata
   );

endinterface

// File: rtl/axis_lane_serializer.sv
// Parallel-to-serial AXI-Stream converter: each accepted input beat of
// BUS_NUM samples (lane 0 earliest) is emitted as BUS_NUM output beats.
// Ports: clk, rst_n (async, active-low), en (input accept enable),
//        bus (slave modport: in_* parallel input, out_* serial output).
module axis_lane_serializer
   import axis_pkg::*;
#(
   parameter int BUS_NUM = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   axis_lane_serializer_if.slave   bus
);

   localparam int            LW   = $clog2(BUS_NUM);
   localparam logic [LW-1:0] LAST = LW'(BUS_NUM - 1);

   typedef enum logic {
      EMPTY,
      SHIFT
   } state_e;

   state_e                state_q, state_d;
   logic [LW-1:0]         lane_q, lane_d;
   sample_t [BUS_NUM-1:0] held_q, held_d;
   logic                  tlast_q, tlast_d;

   logic lane_last;
   logic in_hs;
   logic out_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         lane_q  <= '0;
         held_q  <= '0;
         tlast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         held_q  <= held_d;
         tlast_q <= tlast_d;
      end
   end

   always_comb begin
      lane_last = (lane_q == LAST);

      bus.out_tvalid = (state_q == SHIFT);
      bus.out_tdata  = held_q[lane_q];
      bus.out_tlast  = tlast_q & lane_last;

      // rst_n gates ready so nothing is offered while reset is held.
      // Ready during the final lane lets a new beat load with no bubble.
      bus.in_tready = rst_n & en &
                      ((state_q == EMPTY) |
                       (bus.out_tready & lane_last));

      in_hs  = bus.in_tvalid & bus.in_tready;
      out_hs = bus.out_tvalid & bus.out_tready;

      state_d = state_q;
      lane_d  = lane_q;
      held_d  = held_q;
      tlast_d = tlast_q;

      unique case (state_q)
         EMPTY: begin
            if (in_hs) begin
               state_d = SHIFT;
               lane_d  = '0;
               held_d  = bus.in_tdata;
               tlast_d = bus.in_tlast;
            end
         end
         SHIFT: begin
            unique case (1'b1)
               out_hs & ~lane_last: begin
                  lane_d = lane_q + LW'(1);
               end
               out_hs & lane_last & in_hs: begin
                  lane_d  = '0;
                  held_d  = bus.in_tdata;
                  tlast_d = bus.in_tlast;
               end
               out_hs & lane_last & ~in_hs: begin
                  state_d = EMPTY;
                  lane_d  = '0;
               end
               default: ;
            endcase
         end
         default: begin
            state_d = EMPTY;
            lane_d  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_axis_lane_serializer.sv
// Self-checking bench for axis_lane_serializer, BUS_NUM=2 and BUS_NUM=4.
// Inputs are driven on the falling edge; outputs sampled 1 time unit later.
module tb_axis_lane_serializer;
   import axis_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst2_n, rst4_n, en2, en4;
   int   checks = 0;
   int   errors = 0;

   axis_lane_serializer_if #(.BUS_NUM(2)) i2 ();
   axis_lane_serializer_if #(.BUS_NUM(4)) i4 ();

   axis_lane_serializer #(.BUS_NUM(2)) d2 (
      .clk(clk), .rst_n(rst2_n), .en(en2), .bus(i2.slave)
   );
   axis_lane_serializer #(.BUS_NUM(4)) d4 (
      .clk(clk), .rst_n(rst4_n), .en(en4), .bus(i4.slave)
   );

   task automatic idle();
      i2.in_tvalid = 0; i2.in_tlast = 0; i2.in_tdata = '0;
      i2.out_tready = 1; en2 = 1;
      i4.in_tvalid = 0; i4.in_tlast = 0; i4.in_tdata = '0;
      i4.out_tready = 1; en4 = 1;
   endtask

   task automatic test_reset();
      idle();
      i2.in_tvalid = 1; i4.in_tvalid = 1;
      rst2_n = 1; rst4_n = 1;
      #2;
      rst2_n = 0; rst4_n = 0;
      for (int r = 0; r < 2; r++) begin
         #1;
         checks++;
         if (i2.out_tvalid !== 1'b0 || i2.out_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset2_valid_last got %b%b want 00",
                     i2.out_tvalid, i2.out_tlast);
         end
         checks++;
         if (i2.out_tdata !== '0 || i2.in_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset2_data_rdy got %h/%b want 0/0",
                     i2.out_tdata, i2.in_tready);
         end
         checks++;
         if (i4.out_tvalid !== 1'b0 || i4.out_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset4_valid_last got %b%b want 00",
                     i4.out_tvalid, i4.out_tlast);
         end
         checks++;
         if (i4.out_tdata !== '0 || i4.in_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset4_data_rdy got %h/%b want 0/0",
                     i4.out_tdata, i4.in_tready);
         end
         repeat (2) @(posedge clk);
      end
      @(negedge clk);
      idle();
      rst2_n = 1; rst4_n = 1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      sample_t a0, a1, b0, b1;
      a0 = 16'($urandom); a1 = 16'($urandom);
      b0 = 16'($urandom); b1 = 16'($urandom);
      @(negedge clk);
      i2.in_tvalid = 1; i2.in_tdata = {a1, a0}; i2.in_tlast = 0;
      #1;
      checks++;
      if (i2.in_tready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_rdy_empty got %b want 1", i2.in_tready);
      end
      @(negedge clk);
      i2.in_tdata = {b1, b0}; i2.in_tlast = 1;
      #1;
      checks++;
      if (i2.out_tvalid !== 1 || i2.out_tdata !== a0 || i2.out_tlast !== 0) begin
         errors++;
         $display("FAIL b2b_a0 got %b %h %b want 1 %h 0",
                  i2.out_tvalid, i2.out_tdata, i2.out_tlast, a0);
      end
      @(negedge clk);
      #1;
      checks++;
      if (i2.out_tvalid !== 1 || i2.out_tdata !== a1 || i2.out_tlast !== 0 ||
          i2.in_tready !== 1) begin
         errors++;
         $display("FAIL b2b_a1 got %b %h %b rdy %b want 1 %h 0 rdy 1",
                  i2.out_tvalid, i2.out_tdata, i2.out_tlast, i2.in_tready, a1);
      end
      @(negedge clk);
      i2.in_tvalid = 0;
      #1;
      checks++;
      if (i2.out_tvalid !== 1 || i2.out_tdata !== b0 || i2.out_tlast !== 0) begin
         errors++;
         $display("FAIL b2b_b0 got %b %h %b want 1 %h 0",
                  i2.out_tvalid, i2.out_tdata, i2.out_tlast, b0);
      end
      @(negedge clk);
      #1;
      checks++;
      if (i2.out_tvalid !== 1 || i2.out_tdata !== b1 || i2.out_tlast !== 1) begin
         errors++;
         $display("FAIL b2b_b1 got %b %h %b want 1 %h 1",
                  i2.out_tvalid, i2.out_tdata, i2.out_tlast, b1);
      end
      @(negedge clk);
      #1;
      checks++;
      if (i2.out_tvalid !== 0) begin
         errors++;
         $display("FAIL b2b_empty got %b want 0", i2.out_tvalid);
      end
   endtask

   task automatic test_stall();
      sample_t c0, c1, e0, e1;
      c0 = 16'($urandom); c1 = 16'($urandom);
      e0 = 16'($urandom); e1 = 16'($urandom);
      @(negedge clk);
      i2.in_tvalid = 1; i2.in_tdata = {c1, c0}; i2.in_tlast = 1;
      i2.out_tready = 1;
      @(negedge clk);
      i2.in_tdata = {e1, e0}; i2.in_tlast = 0;
      #1;
      checks++;
      if (i2.out_tdata !== c0 || i2.in_tready !== 0) begin
         errors++;
         $display("FAIL stall_c0 got %h rdy %b want %h rdy 0",
                  i2.out_tdata, i2.in_tready, c0);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         i2.out_tready = 0;
         #1;
         checks++;
         if (i2.out_tvalid !== 1 || i2.out_tdata !== c1 ||
             i2.out_tlast !== 1 || i2.in_tready !== 0) begin
            errors++;
            $display("FAIL stall_hold%0d got %b %h %b rdy %b want 1 %h 1 rdy 0",
                     k, i2.out_tvalid, i2.out_tdata, i2.out_tlast,
                     i2.in_tready, c1);
         end
      end
      @(negedge clk);
      i2.out_tready = 1;
      #1;
      checks++;
      if (i2.out_tdata !== c1 || i2.out_tlast !== 1 || i2.in_tready !== 1) begin
         errors++;
         $display("FAIL stall_release got %h %b rdy %b want %h 1 rdy 1",
                  i2.out_tdata, i2.out_tlast, i2.in_tready, c1);
      end
      @(negedge clk);
      i2.in_tvalid = 0;
      #1;
      checks++;
      if (i2.out_tvalid !== 1 || i2.out_tdata !== e0 || i2.out_tlast !== 0) begin
         errors++;
         $display("FAIL stall_e0 got %b %h %b want 1 %h 0",
                  i2.out_tvalid, i2.out_tdata, i2.out_tlast, e0);
      end
      @(negedge clk);
      #1;
      checks++;
      if (i2.out_tvalid !== 1 || i2.out_tdata !== e1 || i2.out_tlast !== 0) begin
         errors++;
         $display("FAIL stall_e1 got %b %h %b want 1 %h 0",
                  i2.out_tvalid, i2.out_tdata, i2.out_tlast, e1);
      end
      @(negedge clk);
      #1;
      checks++;
      if (i2.out_tvalid !== 0) begin
         errors++;
         $display("FAIL stall_empty got %b want 0", i2.out_tvalid);
      end
   endtask

   task automatic test_bus4();
      int idx = 0;
      @(negedge clk);
      i4.in_tvalid = 1; i4.in_tlast = 1;
      i4.in_tdata = {16'd4, 16'd3, 16'd2, 16'd1};
      i4.out_tready = 1'($urandom_range(1));
      #1;
      checks++;
      if (i4.in_tready !== 1) begin
         errors++;
         $display("FAIL bus4_accept got %b want 1", i4.in_tready);
      end
      for (int c = 0; c < 40 && idx < 4; c++) begin
         @(negedge clk);
         i4.in_tvalid = 0;
         i4.out_tready = 1'($urandom_range(1));
         #1;
         checks++;
         if (i4.out_tvalid !== 1) begin
            errors++;
            $display("FAIL bus4_valid got %b want 1", i4.out_tvalid);
         end
         if (i4.out_tvalid && i4.out_tready) begin
            checks++;
            if (i4.out_tdata !== sample_t'(idx + 1) ||
                i4.out_tlast !== (idx == 3)) begin
               errors++;
               $display("FAIL bus4_beat%0d got %0d %b want %0d %b", idx,
                        i4.out_tdata, i4.out_tlast, idx + 1, idx == 3);
            end
            idx++;
         end
      end
      checks++;
      if (idx != 4) begin
         errors++;
         $display("FAIL bus4_timeout got %0d beats want 4", idx);
      end
      @(negedge clk);
      i4.out_tready = 1;
      #1;
      checks++;
      if (i4.out_tvalid !== 0 || i4.in_tready !== 1) begin
         errors++;
         $display("FAIL bus4_empty got v%b r%b want v0 r1",
                  i4.out_tvalid, i4.in_tready);
      end
   endtask

   task automatic test_en_drain();
      sample_t e[4];
      sample_t f[4];
      for (int k = 0; k < 4; k++) begin
         e[k] = 16'($urandom); f[k] = 16'($urandom);
      end
      @(negedge clk);
      en4 = 1; i4.out_tready = 1; i4.in_tvalid = 1; i4.in_tlast = 0;
      i4.in_tdata = {e[3], e[2], e[1], e[0]};
      @(negedge clk);
      en4 = 0; i4.in_tlast = 1;
      i4.in_tdata = {f[3], f[2], f[1], f[0]};
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checks++;
         if (i4.out_tvalid !== 1 || i4.out_tdata !== e[k] ||
             i4.in_tready !== 0) begin
            errors++;
            $display("FAIL en_drain%0d got %b %h rdy %b want 1 %h rdy 0",
                     k, i4.out_tvalid, i4.out_tdata, i4.in_tready, e[k]);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (i4.out_tvalid !== 0 || i4.in_tready !== 0) begin
         errors++;
         $display("FAIL en_blocked got v%b r%b want v0 r0",
                  i4.out_tvalid, i4.in_tready);
      end
      @(negedge clk);
      en4 = 1;
      #1;
      checks++;
      if (i4.in_tready !== 1) begin
         errors++;
         $display("FAIL en_reenable got %b want 1", i4.in_tready);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         i4.in_tvalid = 0;
         #1;
         checks++;
         if (i4.out_tdata !== f[k] || i4.out_tlast !== (k == 3)) begin
            errors++;
            $display("FAIL en_f%0d got %h %b want %h %b",
                     k, i4.out_tdata, i4.out_tlast, f[k], k == 3);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      i4.in_tvalid = 1; i4.in_tlast = 1; i4.out_tready = 1;
      i4.in_tdata = {16'd12, 16'd11, 16'd10, 16'd9};
      @(negedge clk);
      i4.in_tvalid = 0;
      @(negedge clk);
      #1;
      checks++;
      if (i4.out_tdata !== 16'd10) begin
         errors++;
         $display("FAIL rmid_lane1 got %0d want 10", i4.out_tdata);
      end
      rst4_n = 0;
      #1;
      checks++;
      if (i4.out_tvalid !== 0 || i4.in_tready !== 0 || i4.out_tdata !== '0) begin
         errors++;
         $display("FAIL rmid_async got v%b r%b d%h want v0 r0 d0",
                  i4.out_tvalid, i4.in_tready, i4.out_tdata);
      end
      @(negedge clk);
      @(negedge clk);
      rst4_n = 1;
      i4.in_tvalid = 1; i4.in_tlast = 1;
      i4.in_tdata = {16'd8, 16'd7, 16'd6, 16'd5};
      #1;
      checks++;
      if (i4.in_tready !== 1 || i4.out_tvalid !== 0) begin
         errors++;
         $display("FAIL rmid_release got r%b v%b want r1 v0",
                  i4.in_tready, i4.out_tvalid);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         i4.in_tvalid = 0;
         #1;
         checks++;
         if (i4.out_tvalid !== 1 || i4.out_tdata !== sample_t'(5 + k) ||
             i4.out_tlast !== (k == 3)) begin
            errors++;
            $display("FAIL rmid_out%0d got %b %0d %b want 1 %0d %b", k,
                     i4.out_tvalid, i4.out_tdata, i4.out_tlast, 5 + k, k == 3);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_scoreboard();
      logic [16:0] q[$];
      logic [16:0] e;
      int      beats_left = 2 * 2048;
      int      beat_in_pkt = 0;
      int      cyc = 0;
      int      lasts = 0;
      bit      pend = 0;
      bit      ihs, ohs, exp_rdy;
      bit      prev_stall = 0;
      sample_t prev_d = '0;
      logic    prev_l = 0;
      idle();
      while ((beats_left > 0 || q.size() > 0) && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         if (!pend) i4.in_tvalid = 0;
         if (!pend && beats_left > 0 && $urandom_range(3) != 0) begin
            for (int k = 0; k < 4; k++) i4.in_tdata[k] = 16'($urandom);
            i4.in_tlast = (beat_in_pkt == 2047);
            i4.in_tvalid = 1;
            pend = 1;
         end
         i4.out_tready = ($urandom_range(3) != 0);
         en4 = ($urandom_range(7) != 0);
         #1;
         checks++;
         if (i4.out_tvalid !== (q.size() != 0)) begin
            errors++;
            if (errors < 30)
               $display("FAIL sb_valid cyc %0d got %b want %b",
                        cyc, i4.out_tvalid, q.size() != 0);
         end
         exp_rdy = en4 && (q.size() == 0 || (i4.out_tready && q.size() == 1));
         checks++;
         if (i4.in_tready !== exp_rdy) begin
            errors++;
            if (errors < 30)
               $display("FAIL sb_ready cyc %0d got %b want %b",
                        cyc, i4.in_tready, exp_rdy);
         end
         if (prev_stall) begin
            checks++;
            if (i4.out_tvalid !== 1 || i4.out_tdata !== prev_d ||
                i4.out_tlast !== prev_l) begin
               errors++;
               if (errors < 30)
                  $display("FAIL sb_stable cyc %0d got %b %h %b want 1 %h %b",
                           cyc, i4.out_tvalid, i4.out_tdata, i4.out_tlast,
                           prev_d, prev_l);
            end
         end
         ohs = i4.out_tvalid && i4.out_tready;
         ihs = i4.in_tvalid && i4.in_tready;
         prev_stall = i4.out_tvalid && !i4.out_tready;
         prev_d = i4.out_tdata;
         prev_l = i4.out_tlast;
         if (ohs && q.size() > 0) begin
            e = q.pop_front();
            if (i4.out_tlast) lasts++;
            checks++;
            if (i4.out_tdata !== e[15:0] || i4.out_tlast !== e[16]) begin
               errors++;
               if (errors < 30)
                  $display("FAIL sb_data cyc %0d got %h %b want %h %b",
                           cyc, i4.out_tdata, i4.out_tlast, e[15:0], e[16]);
            end
         end
         if (ihs) begin
            for (int k = 0; k < 4; k++)
               q.push_back({i4.in_tlast && k == 3, i4.in_tdata[k]});
            pend = 0;
            beats_left--;
            beat_in_pkt = (beat_in_pkt == 2047) ? 0 : beat_in_pkt + 1;
         end
      end
      checks++;
      if (beats_left != 0 || q.size() != 0) begin
         errors++;
         $display("FAIL sb_timeout got %0d beats %0d queued want 0 0",
                  beats_left, q.size());
      end
      checks++;
      if (lasts != 2) begin
         errors++;
         $display("FAIL sb_tlast_count got %0d want 2", lasts);
      end
      @(negedge clk);
      idle();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_bus4();
      test_en_drain();
      test_reset_mid();
      test_scoreboard();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
